// File: rtl/mem_if_pipe.sv
// mem_if_pipe: register-slice pipeline between CPU memory ports and on-chip memory.
// Each port has REQ_STAGES request registers and RSP_STAGES read-data registers.
// A per-port valid tracker marks the cycle in which s_rddata holds a read response.
// A per-port counter reports how many reads are outstanding.
//
// Interface contract: there is no backpressure. A request is presented for one
// cycle on s_rd/s_wr and is taken unconditionally unless i_flush is high in that
// cycle. s_rvalid is a single-cycle strobe that has no ready; the CPU must capture
// s_rddata in the cycle in which s_rvalid is high.
module mem_if_pipe #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int NPORT      = 2,
  parameter int REQ_STAGES = 1,
  parameter int RSP_STAGES = 1,
  parameter int MEM_RD_LAT = 1,
  localparam int TOT       = REQ_STAGES + MEM_RD_LAT + RSP_STAGES,
  // The counter is kept at least one bit wide so the port never has zero width.
  localparam int CW        = (TOT > 0) ? $clog2(TOT + 1) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_flush,
  input  logic [NPORT*AW-1:0] s_addr,
  input  logic [NPORT-1:0]    s_rd,
  input  logic [NPORT-1:0]    s_wr,
  input  logic [NPORT*DW-1:0] s_wrdata,
  output logic [NPORT*DW-1:0] s_rddata,
  output logic [NPORT-1:0]    s_rvalid,
  output logic [NPORT*CW-1:0] o_inflight,
  output logic [NPORT-1:0]    o_err,
  output logic [NPORT*AW-1:0] m_addr,
  output logic [NPORT-1:0]    m_rd,
  output logic [NPORT-1:0]    m_wr,
  output logic [NPORT*DW-1:0] m_wrdata,
  input  logic [NPORT*DW-1:0] m_rddata
);

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic acc_rd;
    logic acc_wr;
    logic rvalid;
    logic err_q;
    logic err_d;

    // Stage-0 entry: flush drops the request; rd+wr together is forwarded as a write only
    always_comb begin
      acc_wr = s_wr[p] & ~i_flush;
      acc_rd = s_rd[p] & ~s_wr[p] & ~i_flush;
      err_d  = err_q | (s_rd[p] & s_wr[p]);
    end

    // Sticky rd+wr collision flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
    end

    assign o_err[p]    = err_q;
    assign s_rvalid[p] = rvalid;

    // ---------------- request path ----------------
    if (REQ_STAGES > 0) begin : g_req
      logic [AW-1:0]         addr_q  [REQ_STAGES];
      logic [AW-1:0]         addr_d  [REQ_STAGES];
      logic [DW-1:0]         wdata_q [REQ_STAGES];
      logic [DW-1:0]         wdata_d [REQ_STAGES];
      logic [REQ_STAGES-1:0] rd_q;
      logic [REQ_STAGES-1:0] rd_d;
      logic [REQ_STAGES-1:0] wr_q;
      logic [REQ_STAGES-1:0] wr_d;

      // Shift the request one stage per cycle; flush kills every strobe in flight
      always_comb begin
        addr_d[0]  = s_addr[p*AW +: AW];
        wdata_d[0] = s_wrdata[p*DW +: DW];
        for (int i = 1; i < REQ_STAGES; i++) begin
          addr_d[i]  = addr_q[i-1];
          wdata_d[i] = wdata_q[i-1];
        end
        rd_d    = rd_q << 1;
        wr_d    = wr_q << 1;
        rd_d[0] = acc_rd;
        wr_d[0] = acc_wr;
        if (i_flush) begin
          rd_d = '0;
          wr_d = '0;
        end
      end

      // Request stage registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < REQ_STAGES; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
          end
          rd_q <= '0;
          wr_q <= '0;
        end else begin
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          rd_q    <= rd_d;
          wr_q    <= wr_d;
        end
      end

      assign m_addr[p*AW +: AW]   = addr_q[REQ_STAGES-1];
      assign m_wrdata[p*DW +: DW] = wdata_q[REQ_STAGES-1];
      assign m_rd[p]              = rd_q[REQ_STAGES-1];
      assign m_wr[p]              = wr_q[REQ_STAGES-1];
    end else begin : g_req_bypass
      assign m_addr[p*AW +: AW]   = s_addr[p*AW +: AW];
      assign m_wrdata[p*DW +: DW] = s_wrdata[p*DW +: DW];
      assign m_rd[p]              = acc_rd;
      assign m_wr[p]              = acc_wr;
    end

    // ---------------- read-data path ----------------
    if (RSP_STAGES > 0) begin : g_rsp
      logic [DW-1:0] rsp_q [RSP_STAGES];
      logic [DW-1:0] rsp_d [RSP_STAGES];

      // Read data shifts every cycle; flush leaves it alone because validity lives in the tracker
      always_comb begin
        rsp_d[0] = m_rddata[p*DW +: DW];
        for (int i = 1; i < RSP_STAGES; i++) begin
          rsp_d[i] = rsp_q[i-1];
        end
      end

      // Response stage registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < RSP_STAGES; i++) begin
            rsp_q[i] <= '0;
          end
        end else begin
          rsp_q <= rsp_d;
        end
      end

      assign s_rddata[p*DW +: DW] = rsp_q[RSP_STAGES-1];
    end else begin : g_rsp_bypass
      assign s_rddata[p*DW +: DW] = m_rddata[p*DW +: DW];
    end

    // ---------------- valid tracker and outstanding counter ----------------
    if (TOT > 0) begin : g_trk
      logic [TOT-1:0] trk_q;
      logic [TOT-1:0] trk_d;
      logic [CW-1:0]  cnt_q;
      logic [CW-1:0]  cnt_d;

      // Tracker delays each accepted read by TOT cycles; counter mirrors its popcount
      always_comb begin
        trk_d    = trk_q << 1;
        trk_d[0] = acc_rd;
        cnt_d    = cnt_q;
        if (acc_rd && !rvalid)      cnt_d = cnt_q + CW'(1);
        else if (!acc_rd && rvalid) cnt_d = cnt_q - CW'(1);
        if (i_flush) begin
          trk_d = '0;
          cnt_d = '0;
        end
      end

      // Tracker and counter registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          trk_q <= '0;
          cnt_q <= '0;
        end else begin
          trk_q <= trk_d;
          cnt_q <= cnt_d;
        end
      end

      assign rvalid                 = trk_q[TOT-1];
      assign o_inflight[p*CW +: CW] = cnt_q;
    end else begin : g_trk_bypass
      // With no latency at all a read is answered in the cycle it is issued
      assign rvalid                 = acc_rd;
      assign o_inflight[p*CW +: CW] = '0;
    end
  end

endmodule

// File: tb/tb_mem_if_pipe.sv
// tb_mem_if_pipe: directed, table-driven bench for mem_if_pipe.
// dut_a uses default parameters, dut_b REQ=2/RSP=0/LAT=1, dut_c all latencies zero.
// Each has a small behavioural memory. Inputs are driven 1 ns after the rising
// edge and outputs are sampled 4 ns after it.
module tb_mem_if_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic i_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_bad;

  // ---------------- dut_a: defaults ----------------
  logic [31:0] s_addr_a, s_wrdata_a, s_rddata_a, m_addr_a, m_wrdata_a, m_rddata_a;
  logic [1:0]  s_rd_a, s_wr_a, s_rvalid_a, o_err_a, m_rd_a, m_wr_a;
  logic [3:0]  o_inflight_a;

  mem_if_pipe dut_a (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .s_addr(s_addr_a), .s_rd(s_rd_a), .s_wr(s_wr_a), .s_wrdata(s_wrdata_a),
    .s_rddata(s_rddata_a), .s_rvalid(s_rvalid_a), .o_inflight(o_inflight_a),
    .o_err(o_err_a), .m_addr(m_addr_a), .m_rd(m_rd_a), .m_wr(m_wr_a),
    .m_wrdata(m_wrdata_a), .m_rddata(m_rddata_a)
  );

  // Memory model for dut_a: one-cycle read latency, writes land at the edge
  logic [15:0] mem_a [256];
  logic [15:0] rdp_a [2];
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (m_wr_a[p]) mem_a[m_addr_a[p*16 +: 8]] <= m_wrdata_a[p*16 +: 16];
      if (m_rd_a[p]) rdp_a[p] <= mem_a[m_addr_a[p*16 +: 8]];
    end
  end
  assign m_rddata_a = {rdp_a[1], rdp_a[0]};

  // ---------------- dut_b: REQ=2 RSP=0 LAT=1 ----------------
  logic [31:0] s_addr_b, s_wrdata_b, s_rddata_b, m_addr_b, m_wrdata_b, m_rddata_b;
  logic [1:0]  s_rd_b, s_wr_b, s_rvalid_b, o_err_b, m_rd_b, m_wr_b;
  logic [3:0]  o_inflight_b;

  mem_if_pipe #(.REQ_STAGES(2), .RSP_STAGES(0), .MEM_RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .s_addr(s_addr_b), .s_rd(s_rd_b), .s_wr(s_wr_b), .s_wrdata(s_wrdata_b),
    .s_rddata(s_rddata_b), .s_rvalid(s_rvalid_b), .o_inflight(o_inflight_b),
    .o_err(o_err_b), .m_addr(m_addr_b), .m_rd(m_rd_b), .m_wr(m_wr_b),
    .m_wrdata(m_wrdata_b), .m_rddata(m_rddata_b)
  );

  logic [15:0] mem_b [256];
  logic [15:0] rdp_b;
  always @(posedge clk) begin
    if (m_rd_b[0]) rdp_b <= mem_b[m_addr_b[7:0]];
  end
  assign m_rddata_b = {16'h0000, rdp_b};

  // ---------------- dut_c: zero latency everywhere ----------------
  logic [31:0] s_addr_c, s_wrdata_c, s_rddata_c, m_addr_c, m_wrdata_c, m_rddata_c;
  logic [1:0]  s_rd_c, s_wr_c, s_rvalid_c, o_err_c, m_rd_c, m_wr_c;
  logic [1:0]  o_inflight_c;

  mem_if_pipe #(.REQ_STAGES(0), .RSP_STAGES(0), .MEM_RD_LAT(0)) dut_c (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .s_addr(s_addr_c), .s_rd(s_rd_c), .s_wr(s_wr_c), .s_wrdata(s_wrdata_c),
    .s_rddata(s_rddata_c), .s_rvalid(s_rvalid_c), .o_inflight(o_inflight_c),
    .o_err(o_err_c), .m_addr(m_addr_c), .m_rd(m_rd_c), .m_wr(m_wr_c),
    .m_wrdata(m_wrdata_c), .m_rddata(m_rddata_c)
  );

  logic [15:0] mem_c [256];
  assign m_rddata_c = {16'h0000, mem_c[m_addr_c[7:0]]};

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        fl;
    logic [15:0] a0, d0, a1, d1;
    logic [1:0]  e_mrd, e_mwr, e_rv, e_err;
    logic [1:0]  e_i0, e_i1;
    logic [1:0]  kind;   // 0: none, 1: m_addr/m_wrdata of dp, 2: s_rddata of dp
    int          dp;
    logic [15:0] ea, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic [1:0] rd, input logic [1:0] wr, input logic fl,
                      input logic [15:0] a0, input logic [15:0] d0,
                      input logic [15:0] a1, input logic [15:0] d1,
                      input logic [1:0] mrd, input logic [1:0] mwr,
                      input logic [1:0] rv, input logic [1:0] err,
                      input logic [1:0] i0, input logic [1:0] i1,
                      input logic [1:0] kind, input int dp,
                      input logic [15:0] ea, input logic [15:0] ed);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.e_mrd = mrd; v.e_mwr = mwr; v.e_rv = rv; v.e_err = err;
    v.e_i0 = i0; v.e_i1 = i1; v.kind = kind; v.dp = dp; v.ea = ea; v.ed = ed;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_a(input vec_t v);
    s_rd_a     = v.rd;
    s_wr_a     = v.wr;
    i_flush    = v.fl;
    s_addr_a   = {v.a1, v.a0};
    s_wrdata_a = {v.d1, v.d0};
  endtask

  task automatic idle_all();
    s_rd_a = '0; s_wr_a = '0; s_addr_a = '0; s_wrdata_a = '0;
    s_rd_b = '0; s_wr_b = '0; s_addr_b = '0; s_wrdata_b = '0;
    s_rd_c = '0; s_wr_c = '0; s_addr_c = '0; s_wrdata_c = '0;
    i_flush = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    idle_all();
    for (int i = 0; i < 256; i++) begin
      mem_b[i] = 16'hA000 + 16'(i);
      mem_c[i] = 16'h0000;
    end
    mem_c[5] = 16'h5A5A;
    mem_c[6] = 16'h6B6B;

    //     rd     wr     fl    a0       d0       a1       d1       mrd    mwr    rv     err    i0 i1 kind dp ea       ed
    // write then read-back on port 1 (TOT=3)
    addv(2'b00, 2'b10, 1'b0, 16'h0000, 16'h0000, 16'h0040, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 1, 1, 16'h0040, 16'hBEEF);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b10, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 16'h0040, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 2, 1, 16'h0000, 16'hBEEF);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    // flush cancels a read in flight and a read offered with it
    addv(2'b01, 2'b00, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b01, 2'b00, 1'b1, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 16'h0001, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    // rd+wr collision on port 0 while port 1 reads normally
    addv(2'b11, 2'b01, 1'b0, 16'h0010, 16'h1234, 16'h0040, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b01, 2'b00, 2'b01, 0, 1, 1, 0, 16'h0010, 16'h1234);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 2'b01, 0, 1, 2, 1, 16'h0000, 16'hBEEF);
    // read back the collided write on port 0
    addv(2'b01, 2'b00, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 1, 0, 16'h0010, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 16'h0000, 16'h0000);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0, 2, 0, 16'h0000, 16'h1234);
    addv(2'b00, 2'b00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 16'h0000, 16'h0000);

    // release reset away from the rising edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ---- table-driven part on dut_a ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive_a(vecs[i]);
      #3;
      chk($sformatf("c%0d m_rd", i),     32'(m_rd_a),            32'(vecs[i].e_mrd));
      chk($sformatf("c%0d m_wr", i),     32'(m_wr_a),            32'(vecs[i].e_mwr));
      chk($sformatf("c%0d s_rvalid", i), 32'(s_rvalid_a),        32'(vecs[i].e_rv));
      chk($sformatf("c%0d o_err", i),    32'(o_err_a),           32'(vecs[i].e_err));
      chk($sformatf("c%0d inflight0", i), 32'(o_inflight_a[1:0]), 32'(vecs[i].e_i0));
      chk($sformatf("c%0d inflight1", i), 32'(o_inflight_a[3:2]), 32'(vecs[i].e_i1));
      if (vecs[i].kind == 2'd1) begin
        chk($sformatf("c%0d m_addr", i),   32'(m_addr_a[vecs[i].dp*16 +: 16]),   32'(vecs[i].ea));
        chk($sformatf("c%0d m_wrdata", i), 32'(m_wrdata_a[vecs[i].dp*16 +: 16]), 32'(vecs[i].ed));
      end else if (vecs[i].kind == 2'd2) begin
        chk($sformatf("c%0d s_rddata", i), 32'(s_rddata_a[vecs[i].dp*16 +: 16]), 32'(vecs[i].ed));
      end
    end

    // ---- asynchronous reset with two reads outstanding on dut_a ----
    @(posedge clk); #1;
    idle_all(); s_rd_a = 2'b01; s_addr_a = 32'h0000_0003;
    @(posedge clk); #1;
    s_rd_a = 2'b01; s_addr_a = 32'h0000_0004;
    @(posedge clk); #1;
    idle_all();
    #1;
    chk("rst pre inflight0", 32'(o_inflight_a[1:0]), 32'd2);
    chk("rst pre s_rddata0", 32'(s_rddata_a[15:0]), 32'h1234);
    #1;
    reset = 1'b0;
    #1;
    chk("rst m_rd",      32'(m_rd_a),       32'd0);
    chk("rst m_addr",    m_addr_a,          32'd0);
    chk("rst s_rvalid",  32'(s_rvalid_a),   32'd0);
    chk("rst s_rddata",  s_rddata_a,        32'd0);
    chk("rst inflight",  32'(o_inflight_a), 32'd0);
    chk("rst o_err",     32'(o_err_a),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #4;
      chk($sformatf("post-rst%0d s_rvalid", i), 32'(s_rvalid_a),   32'd0);
      chk($sformatf("post-rst%0d inflight", i), 32'(o_inflight_a), 32'd0);
    end

    // ---- back-to-back reads through dut_b (TOT=3, no response register) ----
    begin
      logic [1:0] exp_rv  [8];
      logic [1:0] exp_inf [8];
      logic [1:0] exp_mrd [8];
      exp_rv  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      exp_inf = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      exp_mrd = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (c < 4) begin
          s_rd_b   = 2'b01;
          s_addr_b = 32'(c);
        end else begin
          s_rd_b   = 2'b00;
          s_addr_b = '0;
        end
        #3;
        chk($sformatf("b%0d s_rvalid", c),  32'(s_rvalid_b),        32'(exp_rv[c]));
        chk($sformatf("b%0d inflight0", c), 32'(o_inflight_b[1:0]), 32'(exp_inf[c]));
        chk($sformatf("b%0d m_rd", c),      32'(m_rd_b),            32'(exp_mrd[c]));
        if (exp_rv[c] == 2'd1)
          chk($sformatf("b%0d s_rddata", c), 32'(s_rddata_b[15:0]), 32'(16'hA000 + 16'(c - 3)));
      end
    end

    // ---- fully combinational configuration dut_c ----
    @(posedge clk); #1;
    s_rd_c = 2'b01; s_addr_c = 32'h0000_0005;
    #3;
    chk("c0 m_rd",     32'(m_rd_c),           32'd1);
    chk("c0 s_rvalid", 32'(s_rvalid_c),       32'd1);
    chk("c0 s_rddata", 32'(s_rddata_c[15:0]), 32'h5A5A);
    chk("c0 inflight", 32'(o_inflight_c),     32'd0);
    @(posedge clk); #1;
    s_addr_c = 32'h0000_0006;
    #3;
    chk("c1 s_rvalid", 32'(s_rvalid_c),       32'd1);
    chk("c1 s_rddata", 32'(s_rddata_c[15:0]), 32'h6B6B);
    chk("c1 inflight", 32'(o_inflight_c),     32'd0);
    @(posedge clk); #1;
    s_rd_c = 2'b00;
    #3;
    chk("c2 m_rd",     32'(m_rd_c),       32'd0);
    chk("c2 s_rvalid", 32'(s_rvalid_c),   32'd0);
    chk("c2 inflight", 32'(o_inflight_c), 32'd0);

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_if_pipe.md
Name: mem_if_pipe

Overview:
- Parametrised register-slice pipeline placed between CPU memory ports and on-chip memory, for timing closure and latency-tolerance testing.
- Inserts configurable request and response stages on NPORT independent ports (port 0 = instruction fetch, port 1 = load/store).
- Tracks in-flight reads per port and produces a per-port read-data-valid strobe.
- Supports a synchronous flush that cancels in-flight requests.

Parameters:
AW, 16, address width
DW, 16, data width
NPORT, 2, number of independent memory ports
REQ_STAGES, 1, register stages on the request path (0 = combinational pass-through)
RSP_STAGES, 1, register stages on the read-data path (0 = pass-through)
MEM_RD_LAT, 1, fixed memory read latency in cycles (>=0)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
i_flush  in  1  synchronous cancel of all in-flight requests
s_addr  in  NPORT*AW  CPU-side address, port p at [p*AW +: AW]
s_rd  in  NPORT  CPU-side read strobe per port
s_wr  in  NPORT  CPU-side write strobe per port
s_wrdata  in  NPORT*DW  CPU-side write data
s_rddata  out  NPORT*DW  read data to CPU
s_rvalid  out  NPORT  one-cycle strobe: s_rddata holds the response to a read
o_inflight  out  NPORT*CW  per-port outstanding reads, CW = clog2(TOT+1), TOT = REQ_STAGES+MEM_RD_LAT+RSP_STAGES
o_err  out  NPORT  sticky per port: rd and wr asserted in the same cycle
m_addr  out  NPORT*AW  memory-side address
m_rd  out  NPORT  memory-side read strobe
m_wr  out  NPORT  memory-side write strobe
m_wrdata  out  NPORT*DW  memory-side write data
m_rddata  in  NPORT*DW  memory read data, valid MEM_RD_LAT cycles after m_rd

Behaviour:
- Reset (reset=0, asynchronous):
  - All request stage registers, response stage registers, tracker bits, counters and o_err clear to 0.
  - Consequently m_rd=m_wr=0, m_addr=m_wrdata=0, s_rvalid=0, s_rddata=0 (when RSP_STAGES>0), o_inflight=0.
  - Reset mid-operation discards every in-flight request; no s_rvalid is produced for it after release.
- Request path:
  - Accepted request = {addr, rd, wr, wrdata} per port, shifted through REQ_STAGES registers every cycle. There is no backpressure.
  - m_* outputs show the stage-REQ_STAGES contents. With REQ_STAGES=0 they are combinational from s_*.
- rd and wr both set on one port in the same cycle:
  - Forwarded as a write only (rd forced to 0 in the stage-0 entry).
  - o_err[p] set. It stays set until reset.
- Response data path:
  - m_rddata shifted through RSP_STAGES registers; s_rddata is the last stage.
  - Data registers are never cleared by flush.
- Valid tracker:
  - Per-port shift register of TOT bits, input = accepted rd (after the rd/wr rule).
  - s_rvalid[p] is the tracker output, asserted exactly TOT cycles after s_rd[p] was sampled.
  - Back-to-back reads yield back-to-back s_rvalid.
  - TOT=0: s_rvalid = s_rd combinationally.
- Counter o_inflight[p]:
  - Increments on an accepted read; decrements on s_rvalid[p].
  - Increment and decrement in the same cycle: unchanged.
  - Never exceeds TOT (guaranteed by the tracker depth); the width CW covers TOT.
  - Equals the popcount of tracker bits at all times.
- Flush (i_flush=1 at an edge):
  - Clears rd/wr in all request stages and all tracker bits.
  - Sets o_inflight to 0.
  - Drops any s_rd/s_wr presented in the same cycle.
  - Addresses and write data in the stages are don't-care.
  - Flush has priority over a simultaneous accept and decrement.
- Write semantics:
  - Writes produce no response and do not affect the tracker.
  - A write reaches memory REQ_STAGES cycles after s_wr.
- Ports are fully independent; flush and reset are global.

Test Plan:
1. Defaults, port 1: s_wr=1, s_addr=0x0040, s_wrdata=0xBEEF at cycle 0 -> m_wr[1]=1, m_addr=0x0040, m_wrdata=0xBEEF at cycle 1 only. Read of 0x0040 at cycle 3 -> s_rvalid[1]=1 with s_rddata=0xBEEF at cycle 6 (TOT=3). o_inflight[1]=1,1,1 during cycles 4-6, then 0 at cycle 7.
2. REQ_STAGES=2, RSP_STAGES=0, MEM_RD_LAT=1, port 0: reads on 4 consecutive cycles of 0x0000..0x0003 -> 4 consecutive s_rvalid starting 3 cycles after the first read, data in address order. o_inflight peaks at 3.
3. Flush: defaults, issue a read at cycle 0, i_flush=1 at cycle 1 together with a new s_rd -> no s_rvalid ever asserted; o_inflight=0 from cycle 2; m_rd=0 at cycle 2.
4. Simultaneous rd+wr on port 0, addr 0x0010, data 0x1234 -> m_wr[0]=1, m_rd[0]=0 one cycle later; o_err[0]=1 and held; no s_rvalid; port 1 unaffected.
5. Reset mid-flight: 2 reads outstanding, assert reset=0 asynchronously between edges -> all outputs immediately 0. Release -> no s_rvalid for the lost reads; o_inflight=0.
6. REQ_STAGES=RSP_STAGES=MEM_RD_LAT=0: s_rd=1, addr 0x0005 -> m_rd and s_rvalid asserted the same cycle; s_rddata = m_rddata combinationally; o_inflight stays 0.
